// File: rtl/alu_issue_ctrl_pkg.sv
// Shared definitions for the ALU issue controller: ALU opcode values,
// major-opcode values of the instruction word and the FSM state type.
package alu_issue_ctrl_pkg;

    // ALU operation codes driven on alu_opcode
    localparam logic [4:0] ALU_ADD        = 5'b00000;
    localparam logic [4:0] ALU_AND        = 5'b00011;
    localparam logic [4:0] ALU_OR         = 5'b00100;
    localparam logic [4:0] ALU_XOR        = 5'b00101;
    localparam logic [4:0] ALU_SLTU       = 5'b01001;
    localparam logic [4:0] ALU_MOD        = 5'b01110;
    localparam logic [4:0] ALU_DIV        = 5'b10000;
    localparam logic [4:0] ALU_LAST_LEGAL = 5'b10000;

    // Major opcodes, instr[31:26]
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_XORI  = 6'b001110;

    // Issue sequence states
    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DECODE,
        ST_EXECUTE,
        ST_WRITEBACK
    } state_t;

endpackage

// File: rtl/alu_issue_decode.sv
// Combinational instruction decoder: splits a 32-bit instruction word into
// register fields, ALU opcode, immediate, destination and a legality flag.
module alu_issue_decode
    import alu_issue_ctrl_pkg::*;
(
    input  logic [31:0] instr,
    output logic [4:0]  rs,
    output logic [4:0]  rt,
    output logic [4:0]  shamt,
    output logic [4:0]  opcode,
    output logic [31:0] imm,
    output logic [4:0]  dest,
    output logic        use_imm,
    output logic        legal
);

    logic [5:0]  major;
    logic [5:0]  funct;
    logic [31:0] imm_sext;
    logic [31:0] imm_zext;

    assign major    = instr[31:26];
    assign funct    = instr[5:0];
    assign rs       = instr[25:21];
    assign rt       = instr[20:16];
    assign imm_sext = {{16{instr[15]}}, instr[15:0]};
    assign imm_zext = {16'h0000, instr[15:0]};

    // Decode the major opcode into ALU controls; unknown majors stay illegal
    always_comb begin
        opcode  = ALU_ADD;
        imm     = 32'h0000_0000;
        dest    = instr[20:16];
        shamt   = 5'd0;
        use_imm = 1'b0;
        legal   = 1'b0;
        case (major)
            OP_RTYPE: begin
                opcode = funct[4:0];
                dest   = instr[15:11];
                shamt  = instr[10:6];
                legal  = !funct[5] && (funct[4:0] <= ALU_LAST_LEGAL);
            end
            OP_ADDI: begin
                opcode  = ALU_ADD;
                imm     = imm_sext;
                use_imm = 1'b1;
                legal   = 1'b1;
            end
            OP_ANDI: begin
                opcode  = ALU_AND;
                imm     = imm_zext;
                use_imm = 1'b1;
                legal   = 1'b1;
            end
            OP_ORI: begin
                opcode  = ALU_OR;
                imm     = imm_zext;
                use_imm = 1'b1;
                legal   = 1'b1;
            end
            OP_XORI: begin
                opcode  = ALU_XOR;
                imm     = imm_zext;
                use_imm = 1'b1;
                legal   = 1'b1;
            end
            OP_SLTI: begin
                // Sign-extended immediate, but the ALU compares unsigned
                opcode  = ALU_SLTU;
                imm     = imm_sext;
                use_imm = 1'b1;
                legal   = 1'b1;
            end
            default: begin
                legal = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/alu_issue_ctrl.sv
// Multi-cycle ALU issue controller: IDLE -> DECODE -> EXECUTE -> WRITEBACK.
// Optional feature macro: ALU_DIV_GUARD_EN -- when defined, a mod/div whose
// register op2 reads zero is rejected in DECODE with an illegal pulse.
// The illegal and rf_we pulses are registered, so each appears in the cycle
// after the state that decides it (DECODE and WRITEBACK respectively).
module alu_issue_ctrl
    import alu_issue_ctrl_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        instr_valid,
    output logic        instr_ready,
    input  logic [31:0] instr,
    output logic [4:0]  rf_ra,
    output logic [4:0]  rf_rb,
    input  logic [31:0] rf_rdata_a,
    input  logic [31:0] rf_rdata_b,
    output logic [4:0]  alu_opcode,
    output logic [31:0] alu_op1,
    output logic [31:0] alu_op2,
    output logic [4:0]  alu_shamt,
    input  logic [31:0] alu_result,
    output logic        rf_we,
    output logic [4:0]  rf_wa,
    output logic [31:0] rf_wdata,
    output logic        illegal
);

    state_t      state_reg;
    state_t      state_next;
    logic [31:0] instr_reg;
    logic [4:0]  dest_reg;
    logic [31:0] result_reg;

    logic [4:0]  dec_rs;
    logic [4:0]  dec_rt;
    logic [4:0]  dec_shamt;
    logic [4:0]  dec_opcode;
    logic [31:0] dec_imm;
    logic [4:0]  dec_dest;
    logic        dec_use_imm;
    logic        dec_legal;
    logic        div_zero;
    logic        issue_fault;

    alu_issue_decode u_decode (
        .instr   (instr_reg),
        .rs      (dec_rs),
        .rt      (dec_rt),
        .shamt   (dec_shamt),
        .opcode  (dec_opcode),
        .imm     (dec_imm),
        .dest    (dec_dest),
        .use_imm (dec_use_imm),
        .legal   (dec_legal)
    );

`ifdef ALU_DIV_GUARD_EN
    assign div_zero = !dec_use_imm && (rf_rdata_b == 32'h0000_0000) &&
                      ((dec_opcode == ALU_MOD) || (dec_opcode == ALU_DIV));
`else
    assign div_zero = 1'b0;
`endif

    assign issue_fault = !dec_legal || div_zero;
    assign instr_ready = (state_reg == ST_IDLE);
    assign rf_ra       = dec_rs;
    assign rf_rb       = dec_rt;

    // Next-state sequencing; faults in DECODE cut the sequence short
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:      if (instr_valid) state_next = ST_DECODE;
            ST_DECODE:    state_next = issue_fault ? ST_IDLE : ST_EXECUTE;
            ST_EXECUTE:   state_next = ST_WRITEBACK;
            ST_WRITEBACK: state_next = ST_IDLE;
            default:      state_next = ST_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) state_reg <= ST_IDLE;
        else       state_reg <= state_next;
    end

    // Instruction latch: instr is looked at only on the handshake edge
    always_ff @(posedge clock or posedge reset) begin
        if (reset)                          instr_reg <= 32'h0000_0000;
        else if (instr_valid && instr_ready) instr_reg <= instr;
    end

    // ALU presentation registers: loaded leaving a clean DECODE, held otherwise
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            alu_opcode <= 5'd0;
            alu_op1    <= 32'h0000_0000;
            alu_op2    <= 32'h0000_0000;
            alu_shamt  <= 5'd0;
            dest_reg   <= 5'd0;
        end else if (state_reg == ST_DECODE && !issue_fault) begin
            alu_opcode <= dec_opcode;
            alu_op1    <= rf_rdata_a;
            alu_op2    <= dec_use_imm ? dec_imm : rf_rdata_b;
            alu_shamt  <= dec_shamt;
            dest_reg   <= dec_dest;
        end
    end

    // Capture the ALU result at the end of EXECUTE
    always_ff @(posedge clock or posedge reset) begin
        if (reset)                         result_reg <= 32'h0000_0000;
        else if (state_reg == ST_EXECUTE)  result_reg <= alu_result;
    end

    // One-cycle write-back and illegal pulses; register 0 is never written
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rf_we    <= 1'b0;
            rf_wa    <= 5'd0;
            rf_wdata <= 32'h0000_0000;
            illegal  <= 1'b0;
        end else begin
            rf_we   <= 1'b0;
            illegal <= (state_reg == ST_DECODE) && issue_fault;
            if (state_reg == ST_WRITEBACK) begin
                rf_we    <= (dest_reg != 5'd0);
                rf_wa    <= dest_reg;
                rf_wdata <= result_reg;
            end
        end
    end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Self-checking bench for alu_issue_ctrl: directed cases plus randomized
// instructions checked against a behavioural model of decode and timing.
module tb_alu_issue_ctrl;

    logic        clock = 1'b0;
    logic        reset;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [4:0]  rf_ra;
    logic [4:0]  rf_rb;
    logic [31:0] rf_rdata_a;
    logic [31:0] rf_rdata_b;
    logic [4:0]  alu_opcode;
    logic [31:0] alu_op1;
    logic [31:0] alu_op2;
    logic [4:0]  alu_shamt;
    logic [31:0] alu_result;
    logic        rf_we;
    logic [4:0]  rf_wa;
    logic [31:0] rf_wdata;
    logic        illegal;

    logic [31:0] regs [32];
    int          checks = 0;
    int          errors = 0;
    string       cur_tx = "reset";

    typedef struct {
        bit        fault;
        bit [4:0]  op;
        bit [31:0] a;
        bit [31:0] b;
        bit [4:0]  sh;
        bit [4:0]  dest;
    } exp_t;

    alu_issue_ctrl dut (
        .clock       (clock),
        .reset       (reset),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instr       (instr),
        .rf_ra       (rf_ra),
        .rf_rb       (rf_rb),
        .rf_rdata_a  (rf_rdata_a),
        .rf_rdata_b  (rf_rdata_b),
        .alu_opcode  (alu_opcode),
        .alu_op1     (alu_op1),
        .alu_op2     (alu_op2),
        .alu_shamt   (alu_shamt),
        .alu_result  (alu_result),
        .rf_we       (rf_we),
        .rf_wa       (rf_wa),
        .rf_wdata    (rf_wdata),
        .illegal     (illegal)
    );

    always #5 clock = ~clock;

    // Environment: register file reads and a behavioural ALU
    function automatic logic [31:0] tb_alu(input logic [4:0] op, input logic [31:0] a,
                                           input logic [31:0] b, input logic [4:0] sh);
        case (op)
            5'd0:    return a + b;
            5'd3:    return a & b;
            5'd4:    return a | b;
            5'd5:    return a ^ b;
            5'd9:    return (a < b) ? 32'd1 : 32'd0;
            5'd14:   return (b == 0) ? a : a % b;
            5'd16:   return (b == 0) ? 32'hFFFF_FFFF : a / b;
            default: return (a << sh) - b + {27'd0, op};
        endcase
    endfunction

    assign rf_rdata_a = regs[rf_ra];
    assign rf_rdata_b = regs[rf_rb];
    always_comb alu_result = tb_alu(alu_opcode, alu_op1, alu_op2, alu_shamt);

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s/%s: got %h expected %h", cur_tx, tag, got, exp);
        end
    endtask

    function automatic logic [31:0] rtype(input int rs, input int rt, input int rd,
                                          input int sh, input int funct);
        return {6'd0, 5'(rs), 5'(rt), 5'(rd), 5'(sh), 6'(funct)};
    endfunction

    function automatic logic [31:0] itype(input int major, input int rs, input int rt,
                                          input int imm);
        return {6'(major), 5'(rs), 5'(rt), 16'(imm)};
    endfunction

    function automatic bit known_major(input logic [5:0] m);
        return (m == 0) || (m == 8) || (m == 10) || (m == 12) || (m == 13) || (m == 14);
    endfunction

    // Reference: what the instruction should do, from the decode table
    function automatic exp_t ref_model(input logic [31:0] w);
        exp_t        e;
        logic [31:0] rt_val;
        logic [31:0] sext;
        logic [31:0] zext;
        rt_val = regs[w[20:16]];
        sext   = 32'($signed(w[15:0]));
        zext   = 32'(w[15:0]);
        e.fault = 1'b0;
        e.op    = 5'd0;
        e.a     = regs[w[25:21]];
        e.b     = zext;
        e.sh    = 5'd0;
        e.dest  = w[20:16];
        case (int'(w[31:26]))
            0: begin
                e.op    = w[4:0];
                e.b     = rt_val;
                e.sh    = w[10:6];
                e.dest  = w[15:11];
                e.fault = (w[5] == 1'b1) || (int'(w[4:0]) > 16);
`ifdef ALU_DIV_GUARD_EN
                if (!e.fault && (e.op == 14 || e.op == 16) && rt_val == 0) e.fault = 1'b1;
`endif
            end
            8:  begin e.op = 5'd0;  e.b = sext; end
            12: begin e.op = 5'd3;  e.b = zext; end
            13: begin e.op = 5'd4;  e.b = zext; end
            14: begin e.op = 5'd5;  e.b = zext; end
            10: begin e.op = 5'd9;  e.b = sext; end
            default: e.fault = 1'b1;
        endcase
        return e;
    endfunction

    // One full transaction: handshake, then cycle-by-cycle checks
    task automatic run_instr(input logic [31:0] w, input string name);
        exp_t        e;
        logic [31:0] wd;
        e      = ref_model(w);
        wd     = tb_alu(e.op, e.a, e.b, e.sh);
        cur_tx = name;
        @(negedge clock);
        check_eq("ready_idle", instr_ready, 1);
        instr_valid = 1'b1;
        instr       = w;
        @(posedge clock); #1;
        instr_valid = 1'b0;
        instr       = $urandom;
        check_eq("rf_ra", rf_ra, w[25:21]);
        check_eq("rf_rb", rf_rb, w[20:16]);
        check_eq("ready_decode", instr_ready, 0);
        check_eq("we_decode", rf_we, 0);
        @(posedge clock); #1;
        if (e.fault) begin
            check_eq("illegal_pulse", illegal, 1);
            check_eq("we_illegal", rf_we, 0);
            check_eq("ready_after_illegal", instr_ready, 1);
            @(posedge clock); #1;
            check_eq("illegal_end", illegal, 0);
            check_eq("we_after_illegal", rf_we, 0);
            $display("tx %-10s instr=%h illegal", name, w);
        end else begin
            check_eq("illegal_exec", illegal, 0);
            check_eq("alu_opcode", alu_opcode, e.op);
            check_eq("alu_op1", alu_op1, e.a);
            check_eq("alu_op2", alu_op2, e.b);
            check_eq("alu_shamt", alu_shamt, e.sh);
            check_eq("ready_exec", instr_ready, 0);
            @(posedge clock); #1;
            check_eq("we_wb", rf_we, 0);
            check_eq("ready_wb", instr_ready, 0);
            @(posedge clock); #1;
            check_eq("we_pulse", rf_we, (e.dest != 0));
            check_eq("illegal_wb", illegal, 0);
            if (e.dest != 0) begin
                check_eq("rf_wa", rf_wa, e.dest);
                check_eq("rf_wdata", rf_wdata, wd);
                regs[e.dest] = wd;
            end
            @(posedge clock); #1;
            check_eq("we_end", rf_we, 0);
            check_eq("ready_end", instr_ready, 1);
            $display("tx %-10s instr=%h op=%0d dest=%0d wdata=%h", name, w, e.op, e.dest, wd);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not end in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] w;
        for (int i = 0; i < 32; i++) regs[i] = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
        regs[0] = 32'd0;
        regs[1] = 32'd5;
        regs[2] = 32'd7;
        regs[6] = 32'd0;

        reset       = 1'b1;
        instr_valid = 1'b0;
        instr       = 32'h0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        @(posedge clock); #1;
        check_eq("ready", instr_ready, 1);
        check_eq("rf_we", rf_we, 0);
        check_eq("illegal", illegal, 0);
        check_eq("rf_ra", rf_ra, 0);
        check_eq("rf_rb", rf_rb, 0);
        check_eq("alu_opcode", alu_opcode, 0);
        check_eq("alu_op1", alu_op1, 0);
        check_eq("alu_op2", alu_op2, 0);
        check_eq("alu_shamt", alu_shamt, 0);
        check_eq("rf_wa", rf_wa, 0);
        check_eq("rf_wdata", rf_wdata, 0);
        $display("tx %-10s idle outputs after reset", "reset");

        run_instr(rtype(1, 2, 3, 0, 0), "add");
        check_eq("add_result", regs[3], 32'd12);
        run_instr(itype(8, 0, 4, 16'hFFFF), "addi");
        check_eq("addi_result", regs[4], 32'hFFFF_FFFF);
        run_instr(itype(12, 1, 5, 16'h8000), "andi");
        run_instr(rtype(1, 2, 7, 0, 6'h11), "funct11");
        run_instr(rtype(1, 2, 0, 0, 0), "add_rd0");
        run_instr(rtype(1, 6, 8, 0, 16), "div0");
        run_instr(itype(10, 1, 9, 16'hFFFF), "slti");

        // Reset in the middle of EXECUTE
        cur_tx = "mid_reset";
        @(negedge clock);
        instr_valid = 1'b1;
        instr       = rtype(1, 2, 10, 0, 0);
        @(posedge clock); #1;
        instr_valid = 1'b0;
        @(posedge clock); #1;
        reset = 1'b1;
        #1;
        check_eq("ready_async", instr_ready, 1);
        check_eq("we_async", rf_we, 0);
        check_eq("illegal_async", illegal, 0);
        @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(posedge clock); #1;
            check_eq("we_after_reset", rf_we, 0);
            check_eq("illegal_after_reset", illegal, 0);
        end
        $display("tx %-10s reset during execute", "mid_reset");
        run_instr(rtype(1, 2, 11, 0, 0), "post_reset");

        for (int n = 0; n < 60; n++) begin
            case ($urandom_range(0, 5))
                0, 1: w = rtype($urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31),
                                $urandom_range(0, 31), $urandom_range(0, 16));
                2:    w = rtype($urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31),
                                $urandom_range(0, 31), $urandom_range(17, 63));
                3, 4: begin
                    case ($urandom_range(0, 4))
                        0:       w = itype(8,  $urandom_range(0, 31), $urandom_range(0, 31), $urandom);
                        1:       w = itype(12, $urandom_range(0, 31), $urandom_range(0, 31), $urandom);
                        2:       w = itype(13, $urandom_range(0, 31), $urandom_range(0, 31), $urandom);
                        3:       w = itype(14, $urandom_range(0, 31), $urandom_range(0, 31), $urandom);
                        default: w = itype(10, $urandom_range(0, 31), $urandom_range(0, 31), $urandom);
                    endcase
                end
                default: begin
                    w = $urandom;
                    while (known_major(w[31:26])) w = $urandom;
                end
            endcase
            run_instr(w, $sformatf("rand%0d", n));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
